// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead add/subtract unit.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic int idx_w(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with two-level carries.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-precision add/subtract that walks one shared 4-bit CLA slice
// over the operands, least-significant nibble first.
module cla_nibble_sequencer
    import cla_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int IW = idx_w(NIBBLES);

    state_t                             state_q;
    logic [IW-1:0]                      idx_q;
    logic                               carry_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   opa_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   opb_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   wrk_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   wrk_d;
    logic [W-1:0]                       sum_q;
    logic                               cout_q;
    logic                               ovf_q;
    logic                               busy_q;
    logic                               done_q;

    logic [NIBBLE_W-1:0] sl_s;
    logic                sl_cout;
    logic                last;
    logic                ovf_d;

    cla4_slice u_slice (
        .a    (opa_q[idx_q]),
        .b    (opb_q[idx_q]),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    assign last = (idx_q == IW'(NIBBLES - 1));

    always_comb begin
        wrk_d        = wrk_q;
        wrk_d[idx_q] = sl_s;
    end

    // opb already holds ~b for subtraction, so one rule covers both ops
    assign ovf_d = (opa_q[NIBBLES-1][NIBBLE_W-1] == opb_q[NIBBLES-1][NIBBLE_W-1])
                && (wrk_d[NIBBLES-1][NIBBLE_W-1] != opa_q[NIBBLES-1][NIBBLE_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            wrk_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        wrk_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    wrk_q   <= wrk_d;
                    carry_q <= sl_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        sum_q   <= wrk_d;
                        cout_q  <= sl_cout;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer against an arithmetic model.
module tb_cla_nibble_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] held_s;
    logic         held_c;
    logic         held_o;

    cla_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unsigned and signed arithmetic on integers, then range tests
    task automatic ref_model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic ts, output logic [W-1:0] es,
                             output logic ec, output logic eo);
        longint ua, ub, sa, sb, r, u, lim;
        lim = longint'(1) << W;
        ua  = longint'(ta);
        ub  = longint'(tb);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
        if (ts) begin
            u  = ua - ub;
            ec = (ua >= ub);
            r  = sa - sb;
        end else begin
            u  = ua + ub;
            ec = (u >= lim);
            r  = sa + sb;
        end
        if (u < 0) u = u + lim;
        es = W'(u % lim);
        eo = (r > lim / 2 - 1) || (r < -(lim / 2));
    endtask

    // Called in cycle 0; returns positioned in the done cycle.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic ts, input bit mess);
        logic [W-1:0] es;
        logic         ec, eo;
        ref_model(ta, tb, ts, es, ec, eo);
        check("idle_busy", busy, 0);
        a = ta; b = tb; sub = ts; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= NIBBLES; i++) begin
            check("busy_hi", busy, 1);
            check("no_done", done, 0);
            check("hold_sum", sum, held_s);
            check("hold_cout", cout, held_c);
            check("hold_ovf", ovf, held_o);
            if (mess) begin
                a = W'($urandom); b = W'($urandom);
                sub = ~sub; start = 1'b1;
            end
            if (i < NIBBLES) tick();
        end
        tick();
        start = 1'b0;
        check("done_hi", done, 1);
        check("done_busy", busy, 0);
        check("sum", sum, es);
        check("cout", cout, ec);
        check("ovf", ovf, eo);
        held_s = es; held_c = ec; held_o = eo;
    endtask

    task automatic after_done();
        tick();
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        held_s = '0; held_c = 1'b0; held_o = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        op(16'h1234, 16'h4321, 1'b0, 1'b0);
        check("plan_5555", sum, 16'h5555);
        after_done();
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("plan_wrap_c", cout, 1);
        after_done();
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("plan_ovf_add", ovf, 1);
        after_done();
        op(16'h0005, 16'h0007, 1'b1, 1'b0);
        check("plan_fffe", sum, 16'hFFFE);
        after_done();
        op(16'h8000, 16'h0001, 1'b1, 1'b0);
        check("plan_ovf_sub", ovf, 1);
        after_done();

        op(16'h0F0F, 16'h1111, 1'b0, 1'b1);
        after_done();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_queue", busy, 0);
        end

        a = 16'h2222; b = 16'h1111; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        held_s = '0; held_c = 1'b0; held_o = 1'b0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            tick();
            check("rst_no_done", done, 0);
        end
        op(16'hABCD, 16'h1234, 1'b1, 1'b0);
        after_done();

        op(16'h0001, 16'h0001, 1'b0, 1'b0);
        check("b2b_first", sum, 16'h0002);
        op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        check("b2b_second", sum, 16'h0100);
        after_done();

        for (int i = 0; i < 24; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) after_done();
        end
        after_done();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle, multi-precision add/subtract controller built around one shared 4-bit carry-lookahead slice. It accepts a wide operand pair on a start strobe and feeds the slice one nibble per cycle, least-significant first. Between cycles it holds the inter-nibble carry in a register. When the last nibble is done it returns the full-width sum, the carry-out and the signed-overflow flag with a one-cycle done pulse. It sits between the control logic and the 4-bit adder datapath, trading latency for area.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..16.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse: sum/cout/ovf just updated.
- sum  out  W  result, held until the next completion.
- cout  out  1  carry out of bit W-1; for sub, 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow of the W-bit result.

## Operation
- States:
  - IDLE, with busy=0.
  - RUN, with busy=1 and nibble index idx counting 0..NIBBLES-1.
- Accept, in IDLE with start=1:
  - latch opa = a and opb = sub ? ~b : b.
  - carry register = sub.
  - idx = 0, go to RUN.
  - Latched operands are immune to later changes on a, b and sub.
- In RUN, every cycle:
  - the slice gets opa[4*idx+:4], opb[4*idx+:4] and the carry register.
  - slice sum nibble is written to the working register at idx.
  - carry register takes the slice cout.
  - idx increments.
- Last RUN cycle (idx = NIBBLES-1):
  - sum is loaded from the working register plus the final nibble.
  - cout is loaded from the final slice cout.
  - ovf is loaded as (opa[W-1] == opb[W-1]) && (sum_new[W-1] != opa[W-1]).
  - done is set for the next cycle, then go to IDLE.
- start while busy=1 is ignored: no queueing, no error flag.
- sum, cout and ovf change only at completion, never mid-computation.
- Wrap-around: sums modulo 2^W; cout and ovf report it, no saturation.

## Timing
- Reset: state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0.
- Reset has priority over start and aborts any computation in progress; partial results are discarded and the outputs take their reset values.
- Latency, with start sampled at the edge ending cycle 0:
  - busy=1 in cycles 1..NIBBLES.
  - At the edge ending cycle NIBBLES, sum/cout/ovf take their new values.
  - done=1 and busy=0 in cycle NIBBLES+1.
- Throughput: start may be asserted in the done cycle and is accepted there (back-to-back). Peak rate is one result per NIBBLES+1 cycles.
- done is registered, exactly one cycle wide, and never high while busy=1.
- busy is registered and rises in the cycle after the accepting edge.
- No combinational path from the inputs to any output.

## Structure
- Shared package cla_pkg holds:
  - NIBBLE_W = 4.
  - The state typedef (IDLE, RUN).
  - A function computing the idx width, clog2(NIBBLES).
- Sub-module cla4_slice: purely combinational 4-bit carry-lookahead adder.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout.
  - Generate/propagate terms per bit; all carries in two-level lookahead form.
  - Instantiated exactly once.
- The top level holds:
  - the FSM;
  - idx counter, carry register and operand registers;
  - the working result register and output registers.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, sub=0, start in cycle 0 -> busy in cycles 1-4; done in cycle 5; sum=0x5555, cout=0, ovf=0.
- Carry across every nibble: a=0xFFFF, b=0x0001 add -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtraction:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Robustness: change a/b/sub and pulse start during cycles 1-4 -> second start ignored; result equals the first operands; done pulses exactly once.
- Reset mid-operation: rst=1 in cycle 2 -> in cycle 3 busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows. A new start afterwards completes normally.
- Back-to-back: start 0x0001+0x0001, then start 0x00FF+0x0001 in its done cycle -> sum=0x0002 with done in cycle 5, then sum=0x0100 with done in cycle 10.
